// File: rtl/ama_riscv_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_arb_pkg
// Description : Shared types and constants for the DMEM arbiter slice
//               (arbiter FSM states, read-return owner, byte-enable width).
// Revision    : 1.0 - initial release
// ============================================================================
package ama_riscv_arb_pkg;

  // Width of the DMEM byte-write-enable bus
  localparam int WE_W = 4;

  // Arbiter state: core-priority operation or one forced host slot
  typedef enum logic [0:0] {
    NORMAL     = 1'b0,
    FORCE_HOST = 1'b1
  } arb_state_t;

  // Who owns the read data coming back from DMEM this cycle
  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    HOST = 2'd2
  } rd_owner_t;

endpackage
`default_nettype wire

// File: rtl/ama_riscv_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_starve_cnt
// Description : Saturating host-starvation counter. Counts refused cycles of a
//               pending host request, saturates at LIMIT, clears on accept.
//               limit_hit flags that one more refusal reaches LIMIT, so the
//               arbiter can schedule the forced grant for the next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ama_riscv_starve_cnt #(
  parameter int LIMIT = 8,
  parameter int W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  localparam logic [W-1:0] C_LIMIT    = W'(LIMIT);
  localparam logic [W-1:0] C_LIMIT_M1 = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  // Saturating count of refused cycles; clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != C_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Independent of inc/clr so the arbiter grant path stays loop-free
  assign limit_hit = (r_cnt >= C_LIMIT_M1);

endmodule
`default_nettype wire

// File: rtl/ama_riscv_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_dmem_arbiter
// Description : Shares the single-port synchronous-read DMEM between the core
//               load/store port (default priority) and a valid/ready host
//               port. A starvation counter forces one host grant, stalling
//               the core for that cycle. Read data is steered back to the
//               requester that issued the access one cycle earlier.
//               Optional macro ARB_PERF_CNT_EN adds host-grant and
//               stall-cycle performance counters (outputs read 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module ama_riscv_dmem_arbiter
  import ama_riscv_arb_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // core load/store port
  input  logic              core_en,
  input  logic [WE_W-1:0]   core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  // host port
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic [WE_W-1:0]   host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rsp_valid,
  output logic [DATA_W-1:0] host_rdata,
  // DMEM port
  output logic              mem_en,
  output logic [WE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // performance counters
  output logic [CNT_W-1:0]  perf_host_grants,
  output logic [CNT_W-1:0]  perf_stall_cycles
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  rd_owner_t         r_rd_owner;
  rd_owner_t         w_rd_owner_next;
  logic              w_core_grant;
  logic              w_host_grant;
  logic              w_starve_inc;
  logic              w_starve_clr;
  logic              w_limit_hit;
  logic              r_host_wr;
  logic [DATA_W-1:0] r_core_rdata_hold;

  // Starvation counter: counts refused cycles of a pending host request
  assign w_starve_inc = host_req_valid && !w_host_grant;
  assign w_starve_clr = w_host_grant;

  ama_riscv_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .W     (8)
  ) u_starve_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (w_starve_inc),
    .clr       (w_starve_clr),
    .limit_hit (w_limit_hit)
  );

  // Arbiter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= NORMAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and grant decisions; grants are blocked while reset is held
  always_comb begin
    w_state_next = r_state;
    w_core_grant = 1'b0;
    w_host_grant = 1'b0;
    core_stall   = 1'b0;
    case (r_state)
      NORMAL: begin
        w_core_grant = core_en;
        w_host_grant = !core_en && host_req_valid;
        // the refusal happening now brings the counter to the limit
        if (host_req_valid && !w_host_grant && w_limit_hit) begin
          w_state_next = FORCE_HOST;
        end
      end
      FORCE_HOST: begin
        core_stall   = 1'b1;
        w_host_grant = host_req_valid;
        // one forced slot only: accepted or abandoned, go back to NORMAL
        w_state_next = NORMAL;
      end
      default: begin
        w_state_next = NORMAL;
      end
    endcase
    if (!rst_n) begin
      w_core_grant = 1'b0;
      w_host_grant = 1'b0;
    end
  end

  assign host_req_ready = w_host_grant;

  // Zero-latency DMEM request mux; unused fields are driven to zero
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_core_grant) begin
      mem_en    = 1'b1;
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (w_host_grant) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // Owner of the access issued this cycle, i.e. of next cycle's mem_rdata
  always_comb begin
    w_rd_owner_next = NONE;
    if (w_core_grant) begin
      w_rd_owner_next = CORE;
    end else if (w_host_grant) begin
      w_rd_owner_next = HOST;
    end
  end

  // Read-return owner and host write flag (write responses carry zero data)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_owner <= NONE;
      r_host_wr  <= 1'b0;
    end else begin
      r_rd_owner <= w_rd_owner_next;
      r_host_wr  <= w_host_grant && (host_we != '0);
    end
  end

  // Capture core read data so a stalled core keeps seeing its last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_rdata_hold <= '0;
    end else if (r_rd_owner == CORE) begin
      r_core_rdata_hold <= mem_rdata;
    end
  end

  assign core_rdata     = (r_rd_owner == CORE) ? mem_rdata : r_core_rdata_hold;
  assign host_rsp_valid = (r_rd_owner == HOST);
  assign host_rdata     = ((r_rd_owner == HOST) && !r_host_wr) ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_host_grants;
  logic [CNT_W-1:0] r_perf_stall_cycles;

  // Free-running wrap-around counters of host accepts and core stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_host_grants  <= '0;
      r_perf_stall_cycles <= '0;
    end else begin
      if (w_host_grant) begin
        r_perf_host_grants <= r_perf_host_grants + 1'b1;
      end
      if (core_stall) begin
        r_perf_stall_cycles <= r_perf_stall_cycles + 1'b1;
      end
    end
  end

  assign perf_host_grants  = r_perf_host_grants;
  assign perf_stall_cycles = r_perf_stall_cycles;
`else
  assign perf_host_grants  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ama_riscv_dmem_arbiter
// Description : Self-checking bench for ama_riscv_dmem_arbiter: a directed
//               vector table, hand-written corner sequences (host-only,
//               starvation, stall data hold, write/read ordering, reset
//               mid-op, perf counters when ARB_PERF_CNT_EN is defined) and a
//               randomized run against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_dmem_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 8;
  localparam int CNT_W  = 32;

  logic              clk;
  logic              rst_n;
  logic              core_en;
  logic [3:0]        core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  logic              host_req_valid;
  logic              host_req_ready;
  logic [3:0]        host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rsp_valid;
  logic [DATA_W-1:0] host_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  perf_host_grants;
  logic [CNT_W-1:0]  perf_stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  ama_riscv_dmem_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (LIMIT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .core_en           (core_en),
    .core_we           (core_we),
    .core_addr         (core_addr),
    .core_wdata        (core_wdata),
    .core_rdata        (core_rdata),
    .core_stall        (core_stall),
    .host_req_valid    (host_req_valid),
    .host_req_ready    (host_req_ready),
    .host_we           (host_we),
    .host_addr         (host_addr),
    .host_wdata        (host_wdata),
    .host_rsp_valid    (host_rsp_valid),
    .host_rdata        (host_rdata),
    .mem_en            (mem_en),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .perf_host_grants  (perf_host_grants),
    .perf_stall_cycles (perf_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read DMEM model (read returns pre-write contents)
  logic [DATA_W-1:0] dmem [0:63];

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] <= $urandom;
    dmem[6'h10] <= 32'hDEADBEEF;
    dmem[6'h20] <= 32'h11111111;
    dmem[6'h30] <= 32'h22222222;
    mem_rdata   <= '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= dmem[mem_addr[5:0]];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) dmem[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ce, input logic [3:0] cwe, input logic [ADDR_W-1:0] ca,
                       input logic [31:0] cwd, input logic hv, input logic [3:0] hwe,
                       input logic [ADDR_W-1:0] ha, input logic [31:0] hwd);
    core_en        = ce;
    core_we        = cwe;
    core_addr      = ca;
    core_wdata     = cwd;
    host_req_valid = hv;
    host_we        = hwe;
    host_addr      = ha;
    host_wdata     = hwd;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rsp_valid"}, {31'd0, host_rsp_valid}, 32'd0);
    check({tag, " host_rdata"}, host_rdata, 32'd0);
    check({tag, " core_rdata"}, core_rdata, 32'd0);
    check({tag, " core_stall"}, {31'd0, core_stall}, 32'd0);
    check({tag, " ready"}, {31'd0, host_req_ready}, 32'd0);
    check({tag, " mem_en"}, {31'd0, mem_en}, 32'd0);
    check({tag, " mem_we"}, {28'd0, mem_we}, 32'd0);
    check({tag, " perf_grants"}, perf_host_grants, 32'd0);
    check({tag, " perf_stalls"}, perf_stall_cycles, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic              ce;
    logic [ADDR_W-1:0] ca;
    logic              hv;
    logic [ADDR_W-1:0] ha;
    logic              exp_ready;
    logic              exp_en;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_rsp;
  } vec_t;

  vec_t vecs[6];

  // Reference-model state (rules-level view of the arbiter)
  logic [31:0] ref_mem [0:63];
  int          m_wait;
  bit          m_forced;
  bit          m_rsp;
  logic [31:0] m_hdata;
  logic [31:0] m_core;
  int          m_grants;
  int          m_stalls;

  initial begin
    rst_n = 1'b0;
    drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- directed vector table ----------------
    vecs[0] = '{ce:0, ca:'h00, hv:0, ha:'h00, exp_ready:0, exp_en:0, exp_addr:'h00, exp_rsp:0};
    vecs[1] = '{ce:1, ca:'h20, hv:0, ha:'h00, exp_ready:0, exp_en:1, exp_addr:'h20, exp_rsp:0};
    vecs[2] = '{ce:0, ca:'h00, hv:1, ha:'h10, exp_ready:1, exp_en:1, exp_addr:'h10, exp_rsp:0};
    vecs[3] = '{ce:1, ca:'h21, hv:1, ha:'h11, exp_ready:0, exp_en:1, exp_addr:'h21, exp_rsp:1};
    vecs[4] = '{ce:0, ca:'h00, hv:1, ha:'h11, exp_ready:1, exp_en:1, exp_addr:'h11, exp_rsp:0};
    vecs[5] = '{ce:0, ca:'h00, hv:0, ha:'h00, exp_ready:0, exp_en:0, exp_addr:'h00, exp_rsp:1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vecs[i].ce, 4'h0, vecs[i].ca, '0, vecs[i].hv, 4'h0, vecs[i].ha, '0);
      #1;
      check($sformatf("vec%0d ready", i), {31'd0, host_req_ready}, {31'd0, vecs[i].exp_ready});
      check($sformatf("vec%0d stall", i), {31'd0, core_stall}, 32'd0);
      check($sformatf("vec%0d mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].exp_en});
      if (vecs[i].exp_en)
        check($sformatf("vec%0d mem_addr", i), {18'd0, mem_addr}, {18'd0, vecs[i].exp_addr});
      else
        check($sformatf("vec%0d mem_we", i), {28'd0, mem_we}, 32'd0);
      check($sformatf("vec%0d rsp", i), {31'd0, host_rsp_valid}, {31'd0, vecs[i].exp_rsp});
    end

    // ---------------- host-only read ----------------
    @(negedge clk);
    drive(0, 4'h0, '0, '0, 1, 4'h0, 'h10, '0);
    #1;
    check("hostonly ready", {31'd0, host_req_ready}, 32'd1);
    check("hostonly stall", {31'd0, core_stall}, 32'd0);
    @(negedge clk);
    drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
    #1;
    check("hostonly rsp", {31'd0, host_rsp_valid}, 32'd1);
    check("hostonly rdata", host_rdata, 32'hDEADBEEF);
    check("hostonly stall2", {31'd0, core_stall}, 32'd0);

    // ---------------- write/read ordering ----------------
    @(negedge clk);
    drive(0, 4'h0, '0, '0, 1, 4'hF, 'h40 & 14'h3F, 32'hCAFEF00D);
    #1;
    check("wr full ready", {31'd0, host_req_ready}, 32'd1);
    @(negedge clk);
    drive(1, 4'h0, 'h40 & 14'h3F, '0, 0, 4'h0, '0, '0);
    #1;
    check("wr ack rsp", {31'd0, host_rsp_valid}, 32'd1);
    check("wr ack rdata", host_rdata, 32'd0);
    @(negedge clk);
    drive(0, 4'h0, '0, '0, 1, 4'h2, 'h40 & 14'h3F, 32'h0000AB00);
    #1;
    check("rd after wr", core_rdata, 32'hCAFEF00D);
    check("wr byte ready", {31'd0, host_req_ready}, 32'd1);
    @(negedge clk);
    drive(1, 4'h0, 'h40 & 14'h3F, '0, 0, 4'h0, '0, '0);
    @(negedge clk);
    drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
    #1;
    check("rd after byte wr", core_rdata, 32'hCAFEAB0D);

    // ---------------- reset mid-operation ----------------
    @(negedge clk);
    drive(0, 4'h0, '0, '0, 1, 4'h0, 'h10, '0);
    #1;
    check("midrst accept", {31'd0, host_req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    #1;
    check("midrst rsp2", {31'd0, host_rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst accept", {31'd0, host_req_ready}, 32'd1);
    @(negedge clk);
    drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
    #1;
    check("postrst rsp", {31'd0, host_rsp_valid}, 32'd1);
    check("postrst rdata", host_rdata, 32'hDEADBEEF);

    // ---------------- starvation x3 with stall data hold ----------------
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        drive(1, 4'h0, 'h20, '0, 1, 4'h0, 'h30, '0);
        #1;
        check($sformatf("starve%0d c%0d ready", k, c), {31'd0, host_req_ready}, 32'd0);
        check($sformatf("starve%0d c%0d stall", k, c), {31'd0, core_stall}, 32'd0);
        if (c >= 1) check($sformatf("starve%0d c%0d core_rdata", k, c), core_rdata, 32'h11111111);
      end
      @(negedge clk);
      #1;
      check($sformatf("force%0d stall", k), {31'd0, core_stall}, 32'd1);
      check($sformatf("force%0d ready", k), {31'd0, host_req_ready}, 32'd1);
      check($sformatf("force%0d mem_addr", k), {18'd0, mem_addr}, 32'h30);
      check($sformatf("force%0d core_rdata", k), core_rdata, 32'h11111111);
      @(negedge clk);
      drive(1, 4'h0, 'h20, '0, 0, 4'h0, '0, '0);
      #1;
      check($sformatf("after%0d stall", k), {31'd0, core_stall}, 32'd0);
      check($sformatf("after%0d ready", k), {31'd0, host_req_ready}, 32'd0);
      check($sformatf("after%0d core_rdata", k), core_rdata, 32'h11111111);
      check($sformatf("after%0d rsp", k), {31'd0, host_rsp_valid}, 32'd1);
      check($sformatf("after%0d host_rdata", k), host_rdata, 32'h22222222);
    end
    @(negedge clk);
    drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
    #1;
`ifdef ARB_PERF_CNT_EN
    check("perf grants", perf_host_grants, 32'd3);
    check("perf stalls", perf_stall_cycles, 32'd3);
`else
    check("perf grants off", perf_host_grants, 32'd0);
    check("perf stalls off", perf_stall_cycles, 32'd0);
`endif

    // ---------------- randomized run against reference model ----------------
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = dmem[i];
    m_wait = 0; m_forced = 0; m_rsp = 0; m_hdata = 0; m_core = 0;
    m_grants = 0; m_stalls = 0;
    begin
      bit          host_hold = 0;
      bit          core_hold = 0;
      logic        ce = 0, hv = 0;
      logic [3:0]  cwe = 0, hwe = 0;
      logic [5:0]  ca = 0, ha = 0;
      logic [31:0] cwd = 0, hwd = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        bit c_go, h_go;
        @(negedge clk);
        if (host_hold) begin
          if ($urandom_range(0, 19) == 0) hv = 0;
        end else begin
          hv  = ($urandom_range(0, 99) < 60);
          ha  = 6'($urandom_range(0, 63));
          hwe = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
          hwd = $urandom;
        end
        if (!core_hold) begin
          ce  = ($urandom_range(0, 99) < 70);
          ca  = 6'($urandom_range(0, 63));
          cwe = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
          cwd = $urandom;
        end
        drive(ce, cwe, {8'd0, ca}, cwd, hv, hwe, {8'd0, ha}, hwd);
        #1;
        // who gets the memory this cycle, from the arbitration rules
        h_go = m_forced ? hv : (!ce && hv);
        c_go = !m_forced && ce;
        check("rnd stall", {31'd0, core_stall}, {31'd0, m_forced});
        check("rnd ready", {31'd0, host_req_ready}, {31'd0, h_go});
        check("rnd mem_en", {31'd0, mem_en}, {31'd0, (h_go || c_go)});
        if (c_go) begin
          check("rnd mem_addr core", {18'd0, mem_addr}, {26'd0, ca});
          check("rnd mem_we core", {28'd0, mem_we}, {28'd0, cwe});
          check("rnd mem_wdata core", mem_wdata, cwd);
        end else if (h_go) begin
          check("rnd mem_addr host", {18'd0, mem_addr}, {26'd0, ha});
          check("rnd mem_we host", {28'd0, mem_we}, {28'd0, hwe});
          check("rnd mem_wdata host", mem_wdata, hwd);
        end else begin
          check("rnd mem_we idle", {28'd0, mem_we}, 32'd0);
        end
        check("rnd rsp_valid", {31'd0, host_rsp_valid}, {31'd0, m_rsp});
        check("rnd host_rdata", host_rdata, m_rsp ? m_hdata : 32'd0);
        check("rnd core_rdata", core_rdata, m_core);

        // advance the model past this clock edge
        if (m_forced) m_stalls++;
        if (c_go) m_core = ref_mem[ca];
        m_rsp   = h_go;
        m_hdata = (h_go && hwe == 4'h0) ? ref_mem[ha] : 32'd0;
        for (int b = 0; b < 4; b++) begin
          if (c_go && cwe[b]) ref_mem[ca][b*8 +: 8] = cwd[b*8 +: 8];
          if (h_go && hwe[b]) ref_mem[ha][b*8 +: 8] = hwd[b*8 +: 8];
        end
        if (h_go) begin
          m_grants++;
          m_wait   = 0;
          m_forced = 0;
        end else if (hv) begin
          m_wait   = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
          m_forced = !m_forced && (m_wait == LIMIT);
        end else begin
          m_forced = 0;
        end
        host_hold = hv && !h_go;
        core_hold = m_forced;
      end
    end
    @(negedge clk);
    drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
    #1;
`ifdef ARB_PERF_CNT_EN
    check("rnd perf grants", perf_host_grants, 32'(m_grants));
    check("rnd perf stalls", perf_stall_cycles, 32'(m_stalls));
`else
    check("rnd perf grants off", perf_host_grants, 32'd0);
    check("rnd perf stalls off", perf_stall_cycles, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
